// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the host-side debug controller: host command and
// acknowledge byte codes, debug-tap field widths, dump length and the
// controller state encoding.
// -----------------------------------------------------------------------------
package debug_pkg;

   // Host command bytes
   localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'

   // Acknowledge bytes returned to the host
   localparam logic [7:0] ACK_OK   = 8'h4B;  // 'K'
   localparam logic [7:0] ACK_ERR  = 8'h3F;  // '?'

   // Debug-tap field widths, in dump order (MSB first)
   localparam int W_PC      = 16;
   localparam int W_ID_EX   = 144;
   localparam int W_EX_MEM  = 32;
   localparam int W_MEM_WB  = 48;
   localparam int W_WB_ID   = 40;
   localparam int W_CTRL    = 24;
   localparam int W_SNAP    = W_PC + W_ID_EX + W_EX_MEM + W_MEM_WB + W_WB_ID + W_CTRL;

   // Snapshot plus trailing status byte
   localparam int W_DUMP    = W_SNAP + 8;
   localparam logic [5:0] DUMP_BYTES = 6'd39;

   typedef enum logic [3:0] {
      IDLE,
      LD_CNT,
      LD_BYTE,
      LD_WR,
      STEP,
      RUN,
      SNAP,
      SEND,
      ACK
   } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// -----------------------------------------------------------------------------
// debug_tx_serializer
// Byte serializer for the debug TX path. Loads either the full 312-bit dump
// (snapshot + status byte) or a single acknowledge byte, then presents the
// bytes MSB first under a valid/ready handshake.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   load_vec   load vec and send DUMP_BYTES bytes
//   vec        dump vector, byte-aligned, MSB byte sent first
//   load_byte  load byte_in and send it alone
//   byte_in    single byte to send
//   ready      downstream accepts data when high together with valid
//   data       byte currently presented
//   valid      data is valid
//   done       one-cycle pulse on acceptance of the last byte
// -----------------------------------------------------------------------------
module debug_tx_serializer
   import debug_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_vec,
   input  logic [W_DUMP-1:0] vec,
   input  logic              load_byte,
   input  logic [7:0]        byte_in,
   input  logic              ready,
   output logic [7:0]        data,
   output logic              valid,
   output logic              done
);

   logic [W_DUMP-1:0] shreg;
   logic [5:0]        remaining;
   logic              accept;

   assign valid  = (remaining != 6'd0);
   assign accept = valid & ready;
   assign done   = accept & (remaining == 6'd1);
   // The presented byte is always the top of the shift register, so it cannot
   // change until the byte is accepted and the register shifts.
   assign data   = shreg[W_DUMP-1 -: 8];

   // NOTE: the wide shift register is reset on purpose: its top byte is the
   // visible TX data, which must read zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         remaining <= 6'd0;
      end else if (load_vec) begin
         shreg     <= vec;
         remaining <= DUMP_BYTES;
      end else if (load_byte) begin
         shreg     <= {byte_in, {(W_DUMP-8){1'b0}}};
         remaining <= 6'd1;
      end else if (accept) begin
         shreg     <= {shreg[W_DUMP-9:0], 8'h00};
         remaining <= remaining - 6'd1;
      end
   end

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Host-side debug controller for the pipelined MIPS core. Decodes host command
// bytes from the UART receiver: 'L' loads program words through the
// instruction-write port, 'S' single-steps the core, 'R' free-runs it until it
// halts. After a step or run the debug taps are snapshotted and dumped to the
// host (39 bytes, MSB first, status byte last). Unknown commands get '?'.
//
// Ports
//   clk                 clock
//   i_reset             asynchronous active-high reset
//   i_rx_data/valid     received byte and its one-cycle strobe
//   o_tx_data/valid     byte to transmit, held until accepted
//   i_tx_ready          transmitter accepts when high with o_tx_valid
//   o_we_IF             one-cycle instruction memory write strobe
//   o_instruction_data  instruction word to write
//   o_instruction_addr  instruction word address
//   o_step              core hold: 1 = frozen, 0 = advance
//   i_end               core has halted
//   i_pc_lsb .. i_ctrl_id_ex  debug taps from the core
// -----------------------------------------------------------------------------
module debug_unit
   import debug_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_IADDR = 8,
   parameter int NB_DUMP  = 304
) (
   input  logic                clk,
   input  logic                i_reset,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic                o_we_IF,
   output logic [NB_DATA-1:0]  o_instruction_data,
   output logic [NB_IADDR-1:0] o_instruction_addr,
   output logic                o_step,
   input  logic                i_end,
   input  logic [W_PC-1:0]     i_pc_lsb,
   input  logic [W_ID_EX-1:0]  i_seg_id_ex,
   input  logic [W_EX_MEM-1:0] i_seg_ex_mem,
   input  logic [W_MEM_WB-1:0] i_seg_mem_wb,
   input  logic [W_WB_ID-1:0]  i_seg_wb_id,
   input  logic [W_CTRL-1:0]   i_ctrl_id_ex
);

   state_t              state;
   state_t              next_state;

   logic [NB_IADDR-1:0] word_idx;
   logic [NB_IADDR-1:0] n_words;
   logic [1:0]          byte_cnt;
   logic [NB_DATA-1:0]  instr_data;
   logic                last_word;

   logic                step_q;
   logic                step_d;
   logic                load_vec;
   logic                load_byte;
   logic [7:0]          ack_code;
   logic                tx_done;
   logic [NB_DUMP-1:0]  snap;

   assign last_word = (word_idx == n_words - NB_IADDR'(1));
   assign snap      = {i_pc_lsb, i_seg_id_ex, i_seg_ex_mem, i_seg_mem_wb, i_seg_wb_id, i_ctrl_id_ex};

   // ---------------------------------------------------------------- state reg
   // o_step is registered from its next value so it changes on the same edge
   // that enters or leaves a step/run cycle, and returns to 1 asynchronously.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= IDLE;
         step_q <= 1'b1;
      end else begin
         state  <= next_state;
         step_q <= step_d;
      end
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: next_state = LD_CNT;
                  CMD_STEP: next_state = STEP;
                  CMD_RUN:  next_state = RUN;
                  default:  next_state = ACK;
               endcase
            end
         end
         LD_CNT: begin
            if (i_rx_valid) next_state = (i_rx_data == 8'h00) ? ACK : LD_BYTE;
         end
         LD_BYTE: begin
            if (i_rx_valid && byte_cnt == 2'd3) next_state = LD_WR;
         end
         LD_WR: begin
            next_state = last_word ? ACK : LD_BYTE;
         end
         // step_q is 0 only in the step cycle; once it is back to 1 (settle
         // cycle, or no step because the core had already ended) take the snapshot.
         STEP: begin
            if (step_q) next_state = SNAP;
         end
         RUN: begin
            if (i_end) next_state = SNAP;
         end
         SNAP: next_state = SEND;
         SEND: begin
            if (tx_done) next_state = IDLE;
         end
         ACK: begin
            if (tx_done) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      step_d    = 1'b1;
      load_vec  = (state == SNAP);
      load_byte = 1'b0;
      ack_code  = ACK_OK;
      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_STEP || i_rx_data == CMD_RUN) begin
                  // A halted core is never released.
                  step_d = i_end;
               end else if (i_rx_data != CMD_LOAD) begin
                  load_byte = 1'b1;
                  ack_code  = ACK_ERR;
               end
            end
         end
         LD_CNT: begin
            if (i_rx_valid && i_rx_data == 8'h00) load_byte = 1'b1;
         end
         LD_WR: begin
            if (last_word) load_byte = 1'b1;
         end
         RUN: step_d = i_end;
         default: ;
      endcase
   end

   assign o_step             = step_q;
   assign o_we_IF            = (state == LD_WR);
   assign o_instruction_addr = word_idx;
   assign o_instruction_data = instr_data;

   // ---------------------------------------------------------------- load path
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         word_idx   <= '0;
         n_words    <= '0;
         byte_cnt   <= 2'd0;
         instr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_rx_valid && i_rx_data == CMD_LOAD) word_idx <= '0;
            end
            LD_CNT: begin
               if (i_rx_valid) begin
                  n_words  <= NB_IADDR'(i_rx_data);
                  byte_cnt <= 2'd0;
               end
            end
            LD_BYTE: begin
               if (i_rx_valid) begin
                  instr_data <= {instr_data[NB_DATA-9:0], i_rx_data};
                  byte_cnt   <= byte_cnt + 2'd1;
               end
            end
            LD_WR: begin
               if (!last_word) word_idx <= word_idx + NB_IADDR'(1);
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- TX path
   debug_tx_serializer u_tx (
      .clk       (clk),
      .rst       (i_reset),
      .load_vec  (load_vec),
      .vec       ({snap, 7'b0, i_end}),
      .load_byte (load_byte),
      .byte_in   (ack_code),
      .ready     (i_tx_ready),
      .data      (o_tx_data),
      .valid     (o_tx_valid),
      .done      (tx_done)
   );

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller that drives the pipelined MIPS core over a byte stream, typically the UART receive and transmit byte interfaces. It decodes host commands and acts on them: loads program words through the core's instruction-write port, single-steps or free-runs the core through its step/hold input, and dumps the core's debug segment/control registers back to the host. It sits between the UART and the processor top level and is the only master of the core's load and step inputs.

## Interface
Parameters
- `NB_DATA`, 32, instruction word width
- `NB_IADDR`, 8, instruction memory address width
- `NB_DUMP`, 304, total width of the snapshot (16+144+32+48+40+24)

Ports
- `clk` in 1: single clock
- `i_reset` in 1: asynchronous, active-high reset
- `i_rx_data` in 8: received byte
- `i_rx_valid` in 1: one-cycle strobe, `i_rx_data` valid
- `o_tx_data` out 8: byte to transmit
- `o_tx_valid` out 1: `o_tx_data` valid
- `i_tx_ready` in 1: transmitter accepts the byte when high together with `o_tx_valid`
- `o_we_IF` out 1: instruction memory write strobe
- `o_instruction_data` out 32: instruction word
- `o_instruction_addr` out 8: instruction word address
- `o_step` out 1: core hold; 1 = frozen, 0 = advance one cycle per clock
- `i_end` in 1: core halted (program finished)
- `i_pc_lsb` in 16, `i_seg_id_ex` in 144, `i_seg_ex_mem` in 32, `i_seg_mem_wb` in 48, `i_seg_wb_id` in 40, `i_ctrl_id_ex` in 24: debug taps from the core

## Operation
- Reset values:
  - `o_step`=1
  - `o_we_IF`=0
  - `o_instruction_addr`=0
  - `o_instruction_data`=0
  - `o_tx_valid`=0
  - `o_tx_data`=0
  - FSM in IDLE
- States: IDLE, LD_CNT, LD_BYTE, LD_WR, STEP, RUN, SNAP, SEND, ACK.
- IDLE decodes each `i_rx_valid` byte:
  - 0x4C 'L': go to LD_CNT.
  - 0x53 'S': go to STEP.
  - 0x52 'R': go to RUN.
  - Any other byte: queue ack byte 0x3F and go to ACK.
- Load:
  - LD_CNT takes the next byte as N. If N=0, send ack 0x4B and return to IDLE.
  - LD_BYTE collects 4 bytes per word, MSB first.
  - LD_WR pulses `o_we_IF` for exactly one cycle. `o_instruction_addr` is the word index 0..N-1; address and data stay stable during the pulse.
  - After word N-1 is written, send ack 0x4B and return to IDLE.
- Step:
  - If `i_end`=1, go directly to SNAP with no step.
  - Otherwise drive `o_step`=0 for exactly one cycle, hold one settle cycle, then go to SNAP.
- Run: drive `o_step`=0 from entry until `i_end` is sampled 1. Set `o_step`=1 on that same clock edge, then go to SNAP. If `i_end`=1 on entry, there are zero run cycles.
- SNAP: capture, in one cycle, `{i_pc_lsb, i_seg_id_ex, i_seg_ex_mem, i_seg_mem_wb, i_seg_wb_id, i_ctrl_id_ex}` into a 304-bit register. Append the status byte `{7'b0, i_end}`.
- SEND: transmit 39 bytes, MSB of the snapshot first; the status byte is last. Then return to IDLE.
- RX bytes arriving in STEP, RUN, SNAP, SEND or ACK are discarded.
- `o_step` is 1 in every state except the step cycle and RUN.

## Timing
- TX handshake:
  - A byte transfers on a rising edge with `o_tx_valid`=1 and `i_tx_ready`=1.
  - `o_tx_data` must not change while valid and not yet accepted.
  - `o_tx_valid` may not drop before acceptance.
  - The next byte may be presented in the cycle after acceptance.
- Load latency: `o_we_IF` asserts the cycle after the 4th byte's `i_rx_valid`.
- Step: `o_step`=0 the cycle after the 'S' byte; snapshot 2 cycles later.
- Dump: first `o_tx_valid` the cycle after SNAP; minimum 39 cycles with `i_tx_ready` held 1.
- Reset mid-operation:
  - Immediate return to reset values.
  - A partial word is never written.
  - A partial dump is abandoned.
  - `o_step` returns to 1 asynchronously.

## Structure
- Shared package `debug_pkg` holds:
  - Command codes 0x4C, 0x53, 0x52.
  - Ack codes 0x4B, 0x3F.
  - Dump byte count 39.
  - Field widths 16/144/32/48/40/24.
  - The FSM state enum.
- Sub-module `debug_tx_serializer`:
  - Loads a 312-bit vector (snapshot plus status byte) or a single byte.
  - Shifts out bytes under the valid/ready handshake with a 6-bit byte counter.
  - Reports `done`.

## Test plan
- 'L', N=2, bytes 12 34 56 78 9A BC DE F0 -> two `o_we_IF` pulses: addr 0 / 0x12345678, addr 1 / 0x9ABCDEF0; then one TX byte 0x4B.
- 'S' with `i_end`=0, `i_pc_lsb`=0x0004 -> exactly one `o_step`=0 cycle; 39 bytes sent, first two 0x00 0x04, last 0x00.
- 'R', core raises `i_end` after 10 run cycles -> `o_step`=0 for exactly those 10 cycles, then 39 bytes with last byte 0x01.
- `i_tx_ready` toggled 1-of-3 cycles during a dump -> `o_tx_data` stable while unaccepted; byte order identical to the `i_tx_ready`=1 case.
- Byte 0x7A in IDLE -> TX 0x3F, no `o_we_IF`, `o_step` remains 1.
- `i_reset` asserted after the 3rd load byte -> no `o_we_IF`; all outputs at reset values; a following 'L' N=1 load writes addr 0.
